// File: rtl/pic_priority_sequencer_pkg.sv
// rtl/pic_priority_sequencer_pkg.sv - shared types, OCW2 codes and helpers for the PIC sequencer
package pic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } state_t;

  // OCW2[7:5] = {R, SL, EOI}
  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] EOI_SP       = 3'b011;
  localparam logic [2:0] ROT_NS       = 3'b101;
  localparam logic [2:0] ROT_SP       = 3'b111;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;

  // Lowest-priority level after reset, so IR0 is highest
  localparam logic [2:0] LP_RESET = 3'd7;

  // Position of a level in the current rotation; 0 is the highest priority
  function automatic logic [2:0] pri_dist(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/pic_priority_sequencer_if.sv
// rtl/pic_priority_sequencer_if.sv - request/acknowledge/command bus between control unit and sequencer
interface pic_priority_sequencer_if;

  logic [7:0] IR;
  logic       LEVEL;
  logic [7:0] IMR;
  logic       AEOI;
  logic       INTA_STB;
  logic       EOI_STB;
  logic [2:0] EOI_CMD;
  logic [2:0] EOI_LVL;
  logic       INT;
  logic [2:0] IR_NUM;
  logic       VEC_VALID;
  logic [7:0] IRR;
  logic [7:0] ISR;

  // Control unit side
  modport master (
    output IR, LEVEL, IMR, AEOI, INTA_STB, EOI_STB, EOI_CMD, EOI_LVL,
    input  INT, IR_NUM, VEC_VALID, IRR, ISR
  );

  // Sequencer side
  modport slave (
    input  IR, LEVEL, IMR, AEOI, INTA_STB, EOI_STB, EOI_CMD, EOI_LVL,
    output INT, IR_NUM, VEC_VALID, IRR, ISR
  );

endinterface

// File: rtl/pic_priority_sequencer_rot_resolver.sv
// rtl/pic_priority_sequencer_rot_resolver.sv - rotating find-first starting just after the lowest-priority level
module pic_rot_resolver
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lp,
  output logic       valid,
  output logic [2:0] idx
);

  logic [2:0] pos;

  // Scan from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    pos   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      pos = lp + 3'd1 + 3'(k);
      if (vec[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/pic_priority_sequencer.sv
// rtl/pic_priority_sequencer.sv - IRR/ISR engine with nested/rotating priority and two-pulse INTA sequencing
module pic_priority_sequencer
  import pic_pkg::*;
#(
  parameter int         NUM_IR   = 8,
  parameter logic [2:0] LP_RESET = pic_pkg::LP_RESET
)
(
  input  logic                     CLK,
  input  logic                     RESET,
  pic_priority_sequencer_if.slave  bus
);

  state_t            state, state_next;
  logic              take1, take2;
  logic              spur;
  logic [NUM_IR-1:0] ir_prev, irr, isr;
  logic [NUM_IR-1:0] irr_next, isr_next;
  logic [NUM_IR-1:0] ack_set, aeoi_clr, eoi_clr;
  logic              int_r, int_req;
  logic [2:0]        ir_num, lp, lp_next, lp_val;
  logic              lp_ld;
  logic              vec_valid;
  logic              rot_aeoi, rot_next;
  logic              cand_valid, top_valid;
  logic [2:0]        cand_idx, top_idx;
  logic              aeoi_fire;

  pic_rot_resolver u_cand (
    .vec   (irr & ~bus.IMR),
    .lp    (lp),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  pic_rot_resolver u_top (
    .vec   (isr),
    .lp    (lp),
    .valid (top_valid),
    .idx   (top_idx)
  );

  // Acknowledge sequencer: first INTA latches the level, second one releases the vector
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and the two acknowledge events
  always_comb begin
    state_next = state;
    take1      = 1'b0;
    take2      = 1'b0;
    case (state)
      IDLE: if (bus.INTA_STB) begin
        take1      = 1'b1;
        state_next = ACK1;
      end
      ACK1: if (bus.INTA_STB) begin
        take2      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // OCW2 decode: ISR clear mask, priority-rotation load and rotate-on-AEOI flag
  always_comb begin
    eoi_clr  = '0;
    lp_ld    = 1'b0;
    lp_val   = lp;
    rot_next = rot_aeoi;
    if (bus.EOI_STB) begin
      case (bus.EOI_CMD)
        EOI_NS: if (top_valid) eoi_clr = onehot8(top_idx);
        EOI_SP: eoi_clr = onehot8(bus.EOI_LVL);
        ROT_NS: if (top_valid) begin
          eoi_clr = onehot8(top_idx);
          lp_ld   = 1'b1;
          lp_val  = top_idx;
        end
        ROT_SP: begin
          eoi_clr = onehot8(bus.EOI_LVL);
          lp_ld   = 1'b1;
          lp_val  = bus.EOI_LVL;
        end
        SET_PRI: begin
          lp_ld  = 1'b1;
          lp_val = bus.EOI_LVL;
        end
        ROT_AEOI_SET: rot_next = 1'b1;
        ROT_AEOI_CLR: rot_next = 1'b0;
        default: ;
      endcase
    end
  end

  // Register next values; ISR clears apply before the acknowledge set so the set wins
  always_comb begin
    aeoi_fire = take2 && bus.AEOI && !spur;
    ack_set   = (take1 && cand_valid) ? onehot8(cand_idx) : '0;
    aeoi_clr  = aeoi_fire ? onehot8(ir_num) : '0;
    if (bus.LEVEL) irr_next = bus.IR & ~ack_set;
    else           irr_next = bus.IR & (irr | ~ir_prev) & ~ack_set;
    isr_next  = (isr & ~(eoi_clr | aeoi_clr)) | ack_set;
    if (lp_ld)                     lp_next = lp_val;
    else if (aeoi_fire && rot_aeoi) lp_next = ir_num;
    else                           lp_next = lp;
    int_req   = cand_valid &&
                (!top_valid || (pri_dist(cand_idx, lp) < pri_dist(top_idx, lp)));
  end

  // Request/service registers, latched level and the INT/VEC_VALID outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_prev   <= '1;
      irr       <= '0;
      isr       <= '0;
      lp        <= LP_RESET;
      rot_aeoi  <= 1'b0;
      ir_num    <= 3'd0;
      spur      <= 1'b0;
      int_r     <= 1'b0;
      vec_valid <= 1'b0;
    end else begin
      ir_prev   <= bus.IR;
      irr       <= irr_next;
      isr       <= isr_next;
      lp        <= lp_next;
      rot_aeoi  <= rot_next;
      vec_valid <= take2;
      if (take1) begin
        ir_num <= cand_valid ? cand_idx : 3'd7;
        spur   <= !cand_valid;
      end
      if (take2)
        int_r <= 1'b0;
      else if (state == IDLE && !take1)
        int_r <= int_req;
    end
  end

  assign bus.INT       = int_r;
  assign bus.IR_NUM    = ir_num;
  assign bus.VEC_VALID = vec_valid;
  assign bus.IRR       = irr;
  assign bus.ISR       = isr;

endmodule

// File: tb/tb_pic_priority_sequencer.sv
// tb/tb_pic_priority_sequencer.sv - directed scoreboard bench for the PIC priority sequencer
module tb_pic_priority_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] exp_q[$];

  pic_priority_sequencer_if bus();

  pic_priority_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_inta();
    bus.INTA_STB = 1'b1;
    tick(1);
    bus.INTA_STB = 1'b0;
  endtask

  task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
    bus.EOI_CMD = cmd;
    bus.EOI_LVL = lvl;
    bus.EOI_STB = 1'b1;
    tick(1);
    bus.EOI_STB = 1'b0;
  endtask

  task automatic ack1(input logic [2:0] exp_num);
    exp_q.push_back(exp_num);
    pulse_inta();
  endtask

  task automatic ack2();
    logic found;
    logic [2:0] e;
    found = 1'b0;
    pulse_inta();
    for (int i = 0; i < 4 && !found; i++) begin
      if (bus.VEC_VALID) found = 1'b1;
      else tick(1);
    end
    chk("vec_valid_seen", 32'(found), 32'd1);
    if (found && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_ir_num", 32'(bus.IR_NUM), 32'(e));
    end
    tick(1);
    chk("vec_valid_one_cycle", 32'(bus.VEC_VALID), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    bus.IR = 8'h00; bus.LEVEL = 1'b0; bus.IMR = 8'h00; bus.AEOI = 1'b0;
    bus.INTA_STB = 1'b0; bus.EOI_STB = 1'b0; bus.EOI_CMD = 3'b010; bus.EOI_LVL = 3'd0;
    tick(3);
    chk("rst_int", 32'(bus.INT), 0);
    chk("rst_irr", 32'(bus.IRR), 0);
    chk("rst_isr", 32'(bus.ISR), 0);
    chk("rst_ir_num", 32'(bus.IR_NUM), 0);
    chk("rst_vec", 32'(bus.VEC_VALID), 0);
    RESET = 1'b0;
    tick(2);

    // Edge mode basic: IR2 and IR5 together
    bus.IR = 8'h24;
    tick(1);
    chk("t1_irr_n1", 32'(bus.IRR), 32'h24);
    chk("t1_int_n1", 32'(bus.INT), 0);
    tick(1);
    chk("t1_int_n2", 32'(bus.INT), 1);
    ack1(3'd2);
    chk("t1_ir_num", 32'(bus.IR_NUM), 2);
    chk("t1_isr", 32'(bus.ISR), 32'h04);
    chk("t1_irr", 32'(bus.IRR), 32'h20);
    chk("t1_int_held", 32'(bus.INT), 1);
    ack2();
    chk("t1_int_drop", 32'(bus.INT), 0);
    tick(3);
    chk("t1_int_blocked", 32'(bus.INT), 0);
    ocw2(3'b001, 3'd0);
    chk("t1_isr_eoi", 32'(bus.ISR), 0);
    tick(1);
    chk("t1_int_ir5", 32'(bus.INT), 1);
    ack1(3'd5);
    ack2();
    bus.IR = 8'h00;
    tick(1);
    ocw2(3'b001, 3'd0);
    tick(2);
    chk("t1_clean_isr", 32'(bus.ISR), 0);

    // Nesting: IR3 in service, IR6 blocked, IR1 nests
    bus.IR = 8'h08;
    tick(2);
    ack1(3'd3);
    ack2();
    chk("t2_isr3", 32'(bus.ISR), 32'h08);
    bus.IR = 8'h48;
    tick(3);
    chk("t2_irr6", 32'(bus.IRR), 32'h40);
    chk("t2_int_ir6", 32'(bus.INT), 0);
    bus.IR = 8'h4A;
    tick(2);
    chk("t2_int_ir1", 32'(bus.INT), 1);
    ack1(3'd1);
    chk("t2_isr_nest", 32'(bus.ISR), 32'h0A);
    ack2();
    bus.IR = 8'h00;
    tick(1);
    ocw2(3'b001, 3'd0);
    chk("t2_isr_pop1", 32'(bus.ISR), 32'h08);
    ocw2(3'b001, 3'd0);
    chk("t2_isr_pop3", 32'(bus.ISR), 0);
    tick(2);

    // Specific rotate: ISR=10, EOI 111 level 4, then IR0+IR5 -> IR5 wins
    bus.IR = 8'h10;
    tick(2);
    ack1(3'd4);
    ack2();
    bus.IR = 8'h00;
    tick(1);
    chk("t3_isr4", 32'(bus.ISR), 32'h10);
    ocw2(3'b111, 3'd4);
    chk("t3_isr_rot", 32'(bus.ISR), 0);
    bus.IR = 8'h21;
    tick(2);
    chk("t3_int", 32'(bus.INT), 1);
    ack1(3'd5);
    chk("t3_ir_num", 32'(bus.IR_NUM), 5);
    ack2();
    bus.IR = 8'h00;
    tick(1);
    ocw2(3'b001, 3'd0);
    chk("t3_clean_isr", 32'(bus.ISR), 0);
    tick(2);

    // AEOI with rotate-on-AEOI: IR3 ack leaves ISR empty and makes IR3 lowest
    ocw2(3'b100, 3'd0);
    bus.AEOI = 1'b1;
    bus.IR = 8'h08;
    tick(2);
    ack1(3'd3);
    chk("t4_isr_during", 32'(bus.ISR), 32'h08);
    ack2();
    chk("t4_isr_aeoi", 32'(bus.ISR), 0);
    bus.IR = 8'h00;
    tick(2);
    bus.IR = 8'h11;
    tick(2);
    ack1(3'd4);
    ack2();
    chk("t4_isr_aeoi2", 32'(bus.ISR), 0);
    bus.IR = 8'h00;
    tick(2);
    bus.AEOI = 1'b0;
    ocw2(3'b000, 3'd0);
    ocw2(3'b110, 3'd7);
    bus.IR = 8'h81;
    tick(2);
    ack1(3'd0);
    ack2();
    bus.IR = 8'h00;
    tick(1);
    ocw2(3'b001, 3'd0);
    chk("t4_clean_isr", 32'(bus.ISR), 0);
    tick(2);

    // Level mode follows IR
    bus.LEVEL = 1'b1;
    bus.IR = 8'h02;
    tick(1);
    chk("t5_level_set", 32'(bus.IRR), 32'h02);
    bus.IR = 8'h00;
    tick(1);
    chk("t5_level_clr", 32'(bus.IRR), 0);
    tick(3);
    bus.LEVEL = 1'b0;

    // Spurious: IR2 pulse gone before INTA
    bus.IR = 8'h04;
    tick(1);
    bus.IR = 8'h00;
    tick(2);
    chk("t6_irr_gone", 32'(bus.IRR), 0);
    ack1(3'd7);
    chk("t6_ir_num7", 32'(bus.IR_NUM), 7);
    chk("t6_isr_spur", 32'(bus.ISR), 0);
    ack2();
    chk("t6_isr_after", 32'(bus.ISR), 0);

    // Reset while in ACK1
    bus.IR = 8'h01;
    tick(2);
    pulse_inta();
    chk("t7_isr1", 32'(bus.ISR), 32'h01);
    chk("t7_int1", 32'(bus.INT), 1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("t7_int_rst", 32'(bus.INT), 0);
    chk("t7_isr_rst", 32'(bus.ISR), 0);
    chk("t7_irr_rst", 32'(bus.IRR), 0);
    pulse_inta();
    chk("t7_no_vec", 32'(bus.VEC_VALID), 0);
    tick(1);
    chk("t7_no_vec2", 32'(bus.VEC_VALID), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
